mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-ported 32-bit memory between the instruction-fetch requester (port A, read-only) and the data-memory requester (port B, read/write). It latches the winning request, drives the memory for a fixed number of cycles, then returns read data with a one-cycle done pulse. Port B has priority, and a starvation counter guarantees port A forward progress. It sits between the IF/MEM pipeline stages and the unified memory model.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles MemEnable is held per access; legal 1..8.
- STARVE_LIMIT, 3: consecutive B grants against a waiting A before A is forced; legal 1..15.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- ReqA  in  1  fetch request, level; held until DoneA is sampled.
- AddrA  in  32  fetch address, stable while ReqA is high.
- ReqB  in  1  data request, level; held until DoneB is sampled.
- AddrB  in  32  data address, stable while ReqB is high.
- WrB  in  1  1 means B is a write.
- WDataB  in  32  B write data.
- MemAddr  out  32  registered memory address.
- MemWData  out  32  registered write data.
- MemWrite  out  1  write strobe, high only during ACCESS of a B write.
- MemEnable  out  1  high for every ACCESS cycle.
- MemRData  in  32  memory read data, valid in the last ACCESS cycle.
- RDataA  out  32  last read result for A.
- RDataB  out  32  last read result for B.
- DoneA  out  1  one-cycle completion pulse for A.
- DoneB  out  1  one-cycle completion pulse for B.
- GrantSel  out  1  current owner; 0 means A, 1 means B.

## Operation
- States:
  - IDLE: any request moves to ACCESS. No request stays in IDLE.
  - ACCESS: lasts MEM_LATENCY cycles, tracked by a down-counter LatCnt, then moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Arbitration happens only in IDLE, on the sampled ReqA/ReqB:
  - Only one requester: that requester wins.
  - Both request: B wins, unless StarveCnt == STARVE_LIMIT, in which case A wins.
- StarveCnt (4 bits):
  - Increments when B wins while ReqA is high.
  - Clears when A wins.
  - Holds otherwise.
  - Never exceeds STARVE_LIMIT.
- On the IDLE→ACCESS edge, the following are registered:
  - GrantSel and the winner's address into MemAddr.
  - If B wins: WDataB into MemWData and WrB into the write latch.
  - If A wins: MemWData holds its previous value and MemWrite stays 0.
- ACCESS:
  - MemEnable is high every cycle.
  - MemWrite equals the latched WrB when B owns the port; otherwise it is 0.
- On the ACCESS→DONE edge, MemRData is captured into RDataA or RDataB according to GrantSel. A B write captures nothing, so RDataB holds.
- DONE:
  - The owner's Done output is 1; MemEnable and MemWrite are 0.
  - RData registers hold until the next read for the same port.
- A requester deasserts Req on the edge where it samples Done=1. Req still high in the following IDLE cycle is treated as a new request.
- Changes to Req or Addr outside IDLE are ignored.

## Timing
- Reset values:
  - State = IDLE; LatCnt, StarveCnt = 0.
  - MemAddr, MemWData, RDataA, RDataB = 0.
  - MemWrite, MemEnable, DoneA, DoneB, GrantSel = 0.
- Cycle numbering: Req is seen in IDLE at cycle 0.
  - ACCESS occupies cycles 1..MEM_LATENCY.
  - DONE occupies cycle MEM_LATENCY+1.
  - IDLE resumes at cycle MEM_LATENCY+2.
- Latency from request to done is MEM_LATENCY+1 cycles. Peak throughput is one access per MEM_LATENCY+2 cycles.
- Requests arriving in the same cycle are resolved by the priority rule. There is no combinational path from Req to any output.
- Reset asserted mid-ACCESS or mid-DONE:
  - The access is abandoned and all outputs return to reset values asynchronously.
  - No Done is issued.
  - Requests still held are re-arbitrated starting in the first IDLE cycle after Reset deasserts.
- GrantSel holds its value through IDLE and changes only on a grant edge.

## Structure
- Shared header mem_arb_defs.vh holds:
  - State encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - The GrantSel encodings: SEL_A=0, SEL_B=1.
- One sub-module: Mux32Bit2To1 instance selecting between AddrA and AddrB. Its select is the combinational next-grant, and its output feeds the MemAddr register.
- The remaining RTL is one always block for the FSM and counters plus registered outputs. Target size is about 150–250 lines.

## Test plan
- Single A read:
  - Stimulus: MEM_LATENCY=2, ReqA with AddrA=0x100, memory returns 0xDEADBEEF.
  - Required response: MemEnable high in cycles 1–2, DoneA=1 in cycle 3, RDataA=0xDEADBEEF, GrantSel=0.
- Simultaneous read requests:
  - Stimulus: ReqA with AddrA=0x100 and ReqB with AddrB=0x200.
  - Required response: B is served first (MemAddr=0x200), then A on the next IDLE (MemAddr=0x100). StarveCnt goes 1→0.
- Starvation bound:
  - Stimulus: STARVE_LIMIT=3, A held continuously, B re-requests immediately after every DoneB.
  - Required response: exactly 3 B grants, then 1 A grant, and the pattern repeats.
- B write:
  - Stimulus: WrB=1, AddrB=0x40, WDataB=0x12345678.
  - Required response: MemWrite=1 only during ACCESS, MemWData=0x12345678, DoneB pulses, RDataB unchanged.
- Reset mid-ACCESS:
  - Stimulus: Reset pulsed in cycle 1 of an A read.
  - Required response: all outputs 0 at once, no DoneA. The held ReqA is granted again after release, with the full MEM_LATENCY+1 latency.
- Held request after done:
  - Stimulus: ReqA kept high one cycle past DoneA.
  - Required response: a second A access starts from that IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and the arbitration rule for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // B wins ties unless A has been passed over STARVE_LIMIT times in a row.
  function automatic logic next_sel(input logic reqa, input logic reqb,
                                    input logic starved);
    return (reqb && !(reqa && starved)) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester A/B, memory and completion signals shared by arbiter and its neighbours.
interface mem_port_arbiter_if;
  logic        ReqA;
  logic [31:0] AddrA;
  logic        ReqB;
  logic [31:0] AddrB;
  logic        WrB;
  logic [31:0] WDataB;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemWrite;
  logic        MemEnable;
  logic [31:0] MemRData;
  logic [31:0] RDataA;
  logic [31:0] RDataB;
  logic        DoneA;
  logic        DoneB;
  logic        GrantSel;

  modport slave (
    input  ReqA, AddrA, ReqB, AddrB, WrB, WDataB, MemRData,
    output MemAddr, MemWData, MemWrite, MemEnable, RDataA, RDataB,
           DoneA, DoneB, GrantSel
  );

  modport master (
    output ReqA, AddrA, ReqB, AddrB, WrB, WDataB, MemRData,
    input  MemAddr, MemWData, MemWrite, MemEnable, RDataA, RDataB,
           DoneA, DoneB, GrantSel
  );
endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit 2:1 mux picking the winning requester address.
module Mux32Bit2To1 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        sel,
  output logic [31:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch (A) / data (B) arbiter for one single-ported memory: B priority,
// A forced after STARVE_LIMIT consecutive B wins, fixed MEM_LATENCY access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [3:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        wr_lat;
  logic        nxt_sel;
  logic [31:0] win_addr;

  assign nxt_sel = next_sel(bus.ReqA, bus.ReqB, starve_cnt == STARVE_MAX);

  Mux32Bit2To1 u_addr_mux (
    .in0 (bus.AddrA),
    .in1 (bus.AddrB),
    .sel (nxt_sel),
    .out (win_addr)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      wr_lat        <= 1'b0;
      bus.MemAddr   <= '0;
      bus.MemWData  <= '0;
      bus.MemWrite  <= 1'b0;
      bus.MemEnable <= 1'b0;
      bus.RDataA    <= '0;
      bus.RDataB    <= '0;
      bus.DoneA     <= 1'b0;
      bus.DoneB     <= 1'b0;
      bus.GrantSel  <= SEL_A;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqA || bus.ReqB) begin
            state         <= ACCESS;
            lat_cnt       <= LAT_INIT;
            bus.GrantSel  <= nxt_sel;
            bus.MemAddr   <= win_addr;
            bus.MemEnable <= 1'b1;
            if (nxt_sel == SEL_B) begin
              bus.MemWData <= bus.WDataB;
              wr_lat       <= bus.WrB;
              bus.MemWrite <= bus.WrB;
              // At the limit A would have won, so this cannot overshoot.
              if (bus.ReqA) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              wr_lat       <= 1'b0;
              bus.MemWrite <= 1'b0;
              starve_cnt   <= '0;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd1) begin
            state         <= DONE;
            lat_cnt       <= '0;
            bus.MemEnable <= 1'b0;
            bus.MemWrite  <= 1'b0;
            if (bus.GrantSel == SEL_A) begin
              bus.RDataA <= bus.MemRData;
              bus.DoneA  <= 1'b1;
            end else begin
              bus.DoneB <= 1'b1;
              if (!wr_lat) bus.RDataB <= bus.MemRData;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.DoneA <= 1'b0;
          bus.DoneB <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand sequences for mem_port_arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int L  = 2;
  localparam int SL = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts negedges until a Done pulse is seen; a timeout counts as a failure.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      cyc++;
      if (bus.DoneA || bus.DoneB) break;
    end
    if (!(bus.DoneA || bus.DoneB)) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no Done after %0d cycles", cyc);
    end
  endtask

  typedef struct {
    logic        reqa;
    logic [31:0] addra;
    logic        reqb;
    logic [31:0] addrb;
    logic        wrb;
    logic [31:0] wdatab;
    logic [31:0] rdata;
    logic        exp_sel;
    logic [31:0] exp_addr;
    logic [31:0] exp_ra;
    logic [31:0] exp_rb;
    logic [31:0] exp_wd;
    logic [3:0]  exp_starve;
  } vec_t;

  vec_t vecs[6];
  string pat;

  initial begin
    int cyc;
    bus.ReqA = 0; bus.AddrA = 0; bus.ReqB = 0; bus.AddrB = 0;
    bus.WrB = 0; bus.WDataB = 0; bus.MemRData = 0;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,        32'hDEADBEEF,
                SEL_A, 32'h100, 32'hDEADBEEF, 32'h0,        32'h0,        4'd0};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'hAAAA0001, 32'hCAFEF00D,
                SEL_B, 32'h200, 32'hDEADBEEF, 32'hCAFEF00D, 32'hAAAA0001, 4'd0};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 32'h12345678, 32'h55555555,
                SEL_B, 32'h40,  32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 4'd0};
    vecs[3] = '{1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 32'h99,       32'h11112222,
                SEL_A, 32'h104, 32'h11112222, 32'hCAFEF00D, 32'h12345678, 4'd0};
    vecs[4] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'hAAAA0002, 32'h33334444,
                SEL_B, 32'h200, 32'h11112222, 32'h33334444, 32'hAAAA0002, 4'd1};
    vecs[5] = '{1'b1, 32'h108, 1'b0, 32'h0,   1'b0, 32'h0,        32'h5,
                SEL_A, 32'h108, 32'h5,        32'h33334444, 32'hAAAA0002, 4'd0};

    // Reset values
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_memaddr", bus.MemAddr, 32'h0);
    chk("rst_ctrl", {28'h0, bus.MemEnable, bus.MemWrite, bus.DoneA, bus.DoneB}, 32'h0);
    chk("rst_grant", 32'(bus.GrantSel), 32'h0);
    chk("rst_rdata", bus.RDataA | bus.RDataB | bus.MemWData, 32'h0);
    Reset = 1'b0;

    // Single transactions from the table
    foreach (vecs[i]) begin
      @(posedge Clk); #1;
      bus.ReqA = vecs[i].reqa; bus.AddrA = vecs[i].addra;
      bus.ReqB = vecs[i].reqb; bus.AddrB = vecs[i].addrb;
      bus.WrB = vecs[i].wrb; bus.WDataB = vecs[i].wdatab;
      bus.MemRData = vecs[i].rdata;
      wait_done(cyc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(L + 2));
      chk($sformatf("v%0d_grant", i), 32'(bus.GrantSel), 32'(vecs[i].exp_sel));
      chk($sformatf("v%0d_doneA", i), 32'(bus.DoneA), 32'(vecs[i].exp_sel == SEL_A));
      chk($sformatf("v%0d_doneB", i), 32'(bus.DoneB), 32'(vecs[i].exp_sel == SEL_B));
      chk($sformatf("v%0d_memaddr", i), bus.MemAddr, vecs[i].exp_addr);
      chk($sformatf("v%0d_rdataA", i), bus.RDataA, vecs[i].exp_ra);
      chk($sformatf("v%0d_rdataB", i), bus.RDataB, vecs[i].exp_rb);
      chk($sformatf("v%0d_memwdata", i), bus.MemWData, vecs[i].exp_wd);
      chk($sformatf("v%0d_en_off", i), {30'h0, bus.MemEnable, bus.MemWrite}, 32'h0);
      chk($sformatf("v%0d_starve", i), 32'(dut.starve_cnt), 32'(vecs[i].exp_starve));
      bus.ReqA = 0; bus.ReqB = 0; bus.WrB = 0;
    end

    // Simultaneous reads: B first, then the still-held A
    @(posedge Clk); #1;
    bus.ReqA = 1; bus.AddrA = 32'h100; bus.ReqB = 1; bus.AddrB = 32'h200;
    bus.WrB = 0; bus.MemRData = 32'h0BADF00D;
    wait_done(cyc);
    chk("sim_first_doneB", 32'(bus.DoneB), 32'h1);
    chk("sim_first_addr", bus.MemAddr, 32'h200);
    chk("sim_starve1", 32'(dut.starve_cnt), 32'h1);
    bus.ReqB = 0;
    wait_done(cyc);
    chk("sim_second_latency", 32'(cyc), 32'(L + 2));
    chk("sim_second_doneA", 32'(bus.DoneA), 32'h1);
    chk("sim_second_addr", bus.MemAddr, 32'h100);
    chk("sim_starve0", 32'(dut.starve_cnt), 32'h0);
    chk("sim_rdataA", bus.RDataA, 32'h0BADF00D);
    bus.ReqA = 0;

    // B write, cycle by cycle
    @(posedge Clk); #1;
    bus.ReqB = 1; bus.WrB = 1; bus.AddrB = 32'h40; bus.WDataB = 32'h12345678;
    bus.MemRData = 32'hFFFFFFFF;
    for (int c = 0; c <= L + 2; c++) begin
      @(negedge Clk);
      chk($sformatf("wr_c%0d_en", c), 32'(bus.MemEnable), 32'(c >= 1 && c <= L));
      chk($sformatf("wr_c%0d_we", c), 32'(bus.MemWrite), 32'(c >= 1 && c <= L));
      chk($sformatf("wr_c%0d_doneB", c), 32'(bus.DoneB), 32'(c == L + 1));
      if (c == L + 1) begin bus.ReqB = 0; bus.WrB = 0; end
    end
    chk("wr_memwdata", bus.MemWData, 32'h12345678);
    chk("wr_memaddr", bus.MemAddr, 32'h40);
    chk("wr_rdataB_hold", bus.RDataB, 32'h0BADF00D);

    // Starvation bound: both held, expect BBBA repeating
    pat = "BBBABBBA";
    @(posedge Clk); #1;
    bus.ReqA = 1; bus.AddrA = 32'h300; bus.ReqB = 1; bus.AddrB = 32'h400;
    for (int k = 0; k < 8; k++) begin
      wait_done(cyc);
      chk($sformatf("starve_g%0d_B", k), 32'(bus.DoneB), 32'(pat[k] == "B"));
      chk($sformatf("starve_g%0d_addr", k), bus.MemAddr,
          (pat[k] == "B") ? 32'h400 : 32'h300);
      if (k == 7) begin bus.ReqA = 0; bus.ReqB = 0; end
    end

    // Reset in the first ACCESS cycle of an A read
    @(posedge Clk); #1;
    bus.ReqA = 1; bus.AddrA = 32'h500; bus.MemRData = 32'h77777777;
    @(negedge Clk);
    @(negedge Clk);
    chk("rma_en_before", 32'(bus.MemEnable), 32'h1);
    Reset = 1'b1;
    #1;
    chk("rma_en", 32'(bus.MemEnable), 32'h0);
    chk("rma_memaddr", bus.MemAddr, 32'h0);
    chk("rma_memwdata", bus.MemWData, 32'h0);
    chk("rma_rdata", bus.RDataA | bus.RDataB, 32'h0);
    chk("rma_done", {30'h0, bus.DoneA, bus.DoneB}, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    chk("rma_done_in_reset", {30'h0, bus.DoneA, bus.DoneB}, 32'h0);
    Reset = 1'b0;
    wait_done(cyc);
    chk("rma_relatency", 32'(cyc), 32'(L + 1));
    chk("rma_doneA", 32'(bus.DoneA), 32'h1);
    chk("rma_rdataA", bus.RDataA, 32'h77777777);
    chk("rma_memaddr_after", bus.MemAddr, 32'h500);

    // ReqA held past DoneA starts a second access from the next IDLE
    bus.MemRData = 32'h88888888;
    wait_done(cyc);
    chk("held_latency", 32'(cyc), 32'(L + 2));
    chk("held_doneA", 32'(bus.DoneA), 32'h1);
    chk("held_rdataA", bus.RDataA, 32'h88888888);
    bus.ReqA = 0;
    repeat (2) @(posedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
